// File: rtl/tlb_cmd_unit.sv
// CP0 TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) driving the 32-entry tlb array.
// Optional feature macro: TLB_RANDOM_EN enables the Random counter used by TLBWR.
module tlb_cmd_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  output logic        req_ready,
  output logic        done,
  input  logic [4:0]  cp0_index,
  input  logic [4:0]  cp0_wired,
  input  logic        wired_we,
  input  logic [18:0] cp0_vpn2,
  input  logic [7:0]  cp0_asid,
  input  logic [11:0] cp0_pagemask,
  input  logic [25:0] cp0_lo0,
  input  logic [25:0] cp0_lo1,
  output logic [4:0]  random,
  output logic        tlb_wen,
  output logic [4:0]  tlb_windex,
  output logic [89:0] tlb_wentry,
  output logic        srch_en,
  output logic [18:0] srch_vpn2,
  output logic [7:0]  srch_asid,
  input  logic        srch_hit,
  input  logic [4:0]  srch_index,
  output logic        rd_en,
  output logic [4:0]  rd_index,
  input  logic [89:0] rd_entry,
  output logic        idx_we,
  output logic        idx_p,
  output logic [4:0]  idx_val,
  output logic        ent_we,
  output logic [18:0] ent_vpn2,
  output logic [7:0]  ent_asid,
  output logic [11:0] ent_pagemask,
  output logic [25:0] ent_lo0,
  output logic [25:0] ent_lo1
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned ENTRY_W = 90;
  localparam logic [IDX_W-1:0] RAND_MAX = 5'd31;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_SWAIT,
    S_READ,
    S_RWAIT,
    S_WRITE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  wr_index;
  logic              wr_g;
  logic [ENTRY_W-1:0] wr_entry;

`ifdef TLB_RANDOM_EN
  logic [IDX_W-1:0] random_q;

  // Random walks down from 31 and reloads once it reaches the wired boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      random_q <= RAND_MAX;
    end else if (wired_we) begin
      random_q <= RAND_MAX;
    end else if (random_q <= cp0_wired) begin
      random_q <= RAND_MAX;
    end else begin
      random_q <= random_q - 5'd1;
    end
  end

  assign random   = random_q;
  assign wr_index = (req_op == OP_TLBWR) ? random_q : cp0_index;
`else
  logic unused_wired;

  assign unused_wired = ^{cp0_wired, wired_we};
  assign random       = RAND_MAX;
  assign wr_index     = cp0_index;
`endif

  // Entry is global only when both halves are marked global
  assign wr_g     = cp0_lo0[0] & cp0_lo1[0];
  assign wr_entry = {cp0_vpn2, cp0_asid, cp0_pagemask, wr_g,
                     cp0_lo0[25:6], cp0_lo0[5:1], cp0_lo1[25:6], cp0_lo1[5:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      tlb_wen    <= 1'b0;
      tlb_windex <= '0;
      tlb_wentry <= '0;
      srch_en    <= 1'b0;
      srch_vpn2  <= '0;
      srch_asid  <= '0;
      rd_en      <= 1'b0;
      rd_index   <= '0;
      idx_we     <= 1'b0;
      ent_we     <= 1'b0;
    end else begin
      done    <= 1'b0;
      tlb_wen <= 1'b0;
      srch_en <= 1'b0;
      rd_en   <= 1'b0;
      idx_we  <= 1'b0;
      ent_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            case (req_op)
              OP_TLBP: begin
                state     <= S_SRCH;
                srch_en   <= 1'b1;
                srch_vpn2 <= cp0_vpn2;
                srch_asid <= cp0_asid;
              end
              OP_TLBR: begin
                state    <= S_READ;
                rd_en    <= 1'b1;
                rd_index <= cp0_index;
              end
              OP_TLBWI, OP_TLBWR: begin
                state      <= S_WRITE;
                tlb_wen    <= 1'b1;
                done       <= 1'b1;
                tlb_windex <= wr_index;
                tlb_wentry <= wr_entry;
              end
            endcase
          end
        end
        S_SRCH: begin
          state  <= S_SWAIT;
          idx_we <= 1'b1;
          done   <= 1'b1;
        end
        S_READ: begin
          state  <= S_RWAIT;
          ent_we <= 1'b1;
          done   <= 1'b1;
        end
        S_SWAIT, S_RWAIT, S_WRITE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array results arrive in the update cycle itself, so the update payload is taken straight from them
  assign idx_p   = idx_we & ~srch_hit;
  assign idx_val = (idx_we && srch_hit) ? srch_index : '0;

  assign ent_vpn2     = ent_we ? rd_entry[89:71] : '0;
  assign ent_asid     = ent_we ? rd_entry[70:63] : '0;
  assign ent_pagemask = ent_we ? rd_entry[62:51] : '0;
  assign ent_lo0      = ent_we ? {rd_entry[49:30], rd_entry[29:25], rd_entry[50]} : '0;
  assign ent_lo1      = ent_we ? {rd_entry[24:5], rd_entry[4:0], rd_entry[50]} : '0;

endmodule
